// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int DVD_W_DEF = 32;
  localparam int DVS_W_DEF = 16;
  localparam int CNT_W     = $clog2(DVD_W_DEF + 1);

  // Quotient reported when the divisor is zero.
  localparam logic [DVD_W_DEF-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_32by16_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int DVS_W = 16
) (
  input  logic [DVS_W-1:0] rem,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_next,
  output logic             qbit
);

  logic [DVS_W:0] trial;

  assign trial = {rem, dvd_bit};
  assign qbit  = (trial >= {1'b0, divisor});
  // After a successful subtract the result is below the divisor, so DVS_W bits suffice.
  assign rem_next = qbit ? DVS_W'(trial - {1'b0, divisor}) : trial[DVS_W-1:0];

endmodule

// File: rtl/seq_divider_32by16.sv
// Sequential 32/16 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional signed (truncating) mode is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_divider_32by16
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
`ifdef SEQ_DIV_SIGNED_EN
  ,
  input  logic             is_signed
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] work;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem_next;
  logic             qbit;
  logic [DVD_W-1:0] dvd_mag;
  logic [DVS_W-1:0] dvs_mag;

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = is_signed & dividend[DVD_W-1];
  assign dvs_neg = is_signed & divisor[DVS_W-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // work holds the unconsumed dividend bits on the left and grows the quotient on the right.
  div_step #(.DVS_W(DVS_W)) u_step (
    .rem      (rem),
    .dvd_bit  (work[DVD_W-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      work        <= '0;
      rem         <= '0;
      dvs         <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= S_DONE;
              out_valid   <= 1'b1;
              quotient    <= DVD_W'(DBZ_QUOT);
              remainder   <= dividend[DVS_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state       <= S_RUN;
              cnt         <= '0;
              work        <= dvd_mag;
              rem         <= '0;
              dvs         <= dvs_mag;
              div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
              neg_q       <= dvd_neg ^ dvs_neg;
              neg_r       <= dvd_neg;
`endif
            end
          end
        end
        S_RUN: begin
          work <= {work[DVD_W-2:0], qbit};
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DVD_W - 1)) begin
            quotient  <= {work[DVD_W-2:0], qbit};
            remainder <= rem_next;
`ifdef SEQ_DIV_SIGNED_EN
            state     <= S_FIX;
`else
            state     <= S_DONE;
            out_valid <= 1'b1;
`endif
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        S_FIX: begin
          // Magnitude result to truncating signed: quotient by sign xor, remainder by dividend sign.
          quotient  <= neg_q ? -quotient : quotient;
          remainder <= neg_r ? -remainder : remainder;
          state     <= S_DONE;
          out_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
